// File: rtl/mul_shift_add_ctrl_pkg.sv
// Shared encodings for the shift-add multiplier: RV32M op codes, FSM states, counter width.
package mul_shift_add_ctrl_pkg;

  localparam int unsigned MulOpW       = 2;
  localparam int unsigned MulBusWidth  = 32;
  localparam int unsigned MulCntWidth  = $clog2(MulBusWidth);

  localparam logic [MulOpW-1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [MulOpW-1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [MulOpW-1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [MulOpW-1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPrep  = 3'd1,
    StIter  = 3'd2,
    StFixup = 3'd3,
    StDone  = 3'd4
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply unit.
interface mul_shift_add_ctrl_if
  import mul_shift_add_ctrl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32
);
  logic                 i_start;
  logic [MulOpW-1:0]    i_mul_op;
  logic [BUS_WIDTH-1:0] i_op_a;
  logic [BUS_WIDTH-1:0] i_op_b;
  logic                 o_busy;
  logic                 o_done;
  logic [BUS_WIDTH-1:0] o_result;

  modport master (
    output i_start, i_mul_op, i_op_a, i_op_b,
    input  o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_mul_op, i_op_a, i_op_b,
    output o_busy, o_done, o_result
  );
endinterface

// File: rtl/mul_shift_add_ctrl_adder.sv
// Plain BUS_WIDTH adder shared with the ALU; overflow flag reports signed overflow.
module mul_shift_add_ctrl_adder #(
  parameter int unsigned BUS_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0] i_x,
  input  logic [BUS_WIDTH-1:0] i_y,
  output logic [BUS_WIDTH-1:0] o_sum,
  output logic                 o_overflow_flag
);

  always_comb begin
    o_sum           = i_x + i_y;
    o_overflow_flag = (i_x[BUS_WIDTH-1] == i_y[BUS_WIDTH-1]) &&
                      (o_sum[BUS_WIDTH-1] != i_x[BUS_WIDTH-1]);
  end

endmodule

// File: rtl/mul_shift_add_ctrl.sv
// Multi-cycle RV32M multiplier: magnitudes are multiplied by W shift-add steps on the shared
// adder, then the 2W-bit product is negated if the operand signs differ.
module mul_shift_add_ctrl
  import mul_shift_add_ctrl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mul_shift_add_ctrl_if.slave  bus
);

  localparam int unsigned CntW  = $clog2(BUS_WIDTH);
  localparam int unsigned ProdW = 2 * BUS_WIDTH;
  localparam logic [CntW-1:0] CntLast = CntW'(BUS_WIDTH - 1);

  mul_state_e           r_state;
  logic [MulOpW-1:0]    r_op;
  logic [BUS_WIDTH-1:0] r_a;
  logic [BUS_WIDTH-1:0] r_hi;
  logic [BUS_WIDTH-1:0] r_lo;
  logic                 r_neg;
  logic [CntW-1:0]      r_cnt;
  logic [BUS_WIDTH-1:0] r_result;

  logic                 w_a_signed;
  logic                 w_b_signed;
  logic [BUS_WIDTH-1:0] w_mag_a;
  logic [BUS_WIDTH-1:0] w_mag_b;
  logic                 w_neg;
  logic [BUS_WIDTH-1:0] w_sum;
  logic                 w_unused_ovf;
  logic                 w_carry;
  logic [BUS_WIDTH:0]   w_step;
  logic [ProdW-1:0]     w_fix;

  mul_shift_add_ctrl_adder #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_adder (
    .i_x             (r_hi),
    .i_y             (r_a),
    .o_sum           (w_sum),
    .o_overflow_flag (w_unused_ovf)
  );

  always_comb begin
    w_a_signed = (r_op == MUL_OP_MULH) || (r_op == MUL_OP_MULHSU);
    w_b_signed = (r_op == MUL_OP_MULH);
    // Two's-complement negate of INT_MIN yields 2^(W-1), which is the correct unsigned magnitude
    w_mag_a    = (w_a_signed && r_a[BUS_WIDTH-1]) ? (~r_a + BUS_WIDTH'(1)) : r_a;
    w_mag_b    = (w_b_signed && r_lo[BUS_WIDTH-1]) ? (~r_lo + BUS_WIDTH'(1)) : r_lo;
    w_neg      = (w_a_signed && r_a[BUS_WIDTH-1]) ^ (w_b_signed && r_lo[BUS_WIDTH-1]);
    w_carry    = (r_hi[BUS_WIDTH-1] & r_a[BUS_WIDTH-1]) |
                 ((r_hi[BUS_WIDTH-1] | r_a[BUS_WIDTH-1]) & ~w_sum[BUS_WIDTH-1]);
    w_step     = r_lo[0] ? {w_carry, w_sum} : {1'b0, r_hi};
    w_fix      = r_neg ? (~{r_hi, r_lo} + ProdW'(1)) : {r_hi, r_lo};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (bus.i_start) begin
            r_op    <= bus.i_mul_op;
            r_a     <= bus.i_op_a;
            r_lo    <= bus.i_op_b;
            r_state <= StPrep;
          end else begin
            r_state <= StIdle;
          end
        end
        StPrep: begin
          r_a     <= w_mag_a;
          r_lo    <= w_mag_b;
          r_hi    <= '0;
          r_neg   <= w_neg;
          r_cnt   <= '0;
          r_state <= StIter;
        end
        StIter: begin
          r_hi  <= w_step[BUS_WIDTH:1];
          r_lo  <= {w_step[0], r_lo[BUS_WIDTH-1:1]};
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == CntLast) begin
            r_state <= StFixup;
          end
        end
        StFixup: begin
          {r_hi, r_lo} <= w_fix;
          r_result     <= (r_op == MUL_OP_MUL) ? w_fix[BUS_WIDTH-1:0] : w_fix[ProdW-1:BUS_WIDTH];
          r_state      <= StDone;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.o_busy   = (r_state == StPrep) || (r_state == StIter) || (r_state == StFixup);
    bus.o_done   = (r_state == StDone);
    bus.o_result = r_result;
  end

endmodule

// File: tb/tb_mul_shift_add_ctrl.sv
// Directed and random checks of the shift-add multiplier against a 64-bit arithmetic model.
module tb_mul_shift_add_ctrl;
  import mul_shift_add_ctrl_pkg::*;

  localparam int unsigned W = 32;
  localparam int Latency = W + 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] prev_result;

  mul_shift_add_ctrl_if #(.BUS_WIDTH(W)) bus ();

  mul_shift_add_ctrl #(
    .BUS_WIDTH(W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa = (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ? longint'($signed(a)) :
                                                       longint'({32'b0, a});
    sb = (op == MUL_OP_MULH) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(sa * sb);
    return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the start is taken on the next rising edge.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.i_start  = 1'b1;
    bus.i_mul_op = op;
    bus.i_op_a   = a;
    bus.i_op_b   = b;
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] exp, input bit poke,
                           input bit chain, input logic [1:0] c_op, input logic [W-1:0] c_a,
                           input logic [W-1:0] c_b);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.i_start = 1'b0;
        chk({tag, " busy_after_accept"}, 64'(bus.o_busy), 64'd1);
        chk({tag, " result_held"}, 64'(bus.o_result), 64'(prev_result));
        bus.i_op_a   = $urandom;
        bus.i_op_b   = $urandom;
        bus.i_mul_op = 2'($urandom);
      end
      if (poke && n == 10) bus.i_start = 1'b1;
      if (poke && n == 11) bus.i_start = 1'b0;
      if (bus.o_done) break;
    end
    chk({tag, " latency"}, 64'(n), 64'(Latency));
    chk({tag, " result"}, 64'(bus.o_result), 64'(exp));
    chk({tag, " busy_at_done"}, 64'(bus.o_busy), 64'd0);
    prev_result = exp;
    if (chain) begin
      start_op(c_op, c_a, c_b);
    end else begin
      @(negedge clk);
      chk({tag, " done_single"}, 64'(bus.o_done), 64'd0);
      chk({tag, " idle_busy"}, 64'(bus.o_busy), 64'd0);
    end
  endtask

  initial begin
    int saw;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    clk          = 1'b0;
    rst          = 1'b1;
    checks       = 0;
    errors       = 0;
    prev_result  = '0;
    bus.i_start  = 1'b0;
    bus.i_mul_op = '0;
    bus.i_op_a   = '0;
    bus.i_op_b   = '0;

    repeat (2) @(negedge clk);
    chk("reset busy", 64'(bus.o_busy), 64'd0);
    chk("reset done", 64'(bus.o_done), 64'd0);
    chk("reset result", 64'(bus.o_result), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", 64'(bus.o_busy), 64'd0);

    start_op(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhu_max", 32'hFFFF_FFFE, 0, 0, '0, '0, '0);
    start_op(MUL_OP_MUL, 32'hFFFF_FFFF, 32'h0000_0007);
    wait_done("mul_m1x7", 32'hFFFF_FFF9, 0, 0, '0, '0, '0);
    start_op(MUL_OP_MULH, 32'hFFFF_FFFF, 32'h0000_0007);
    wait_done("mulh_m1x7", 32'hFFFF_FFFF, 0, 0, '0, '0, '0);
    start_op(MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000);
    wait_done("mulh_min2", 32'h4000_0000, 0, 0, '0, '0, '0);
    start_op(MUL_OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("mulhsu_min", 32'h8000_0000, 0, 0, '0, '0, '0);

    // Start pulsed mid-ITER with different operands must be ignored
    start_op(MUL_OP_MULH, 32'h1234_5678, 32'hFEDC_BA98);
    wait_done("poke_iter", model(MUL_OP_MULH, 32'h1234_5678, 32'hFEDC_BA98), 1, 0, '0, '0, '0);

    start_op(MUL_OP_MULHU, 32'hDEAD_BEEF, 32'h0000_1000);
    wait_done("b2b_first", 32'h0000_0DEA, 0, 1, MUL_OP_MUL, 32'h0000_0003, 32'hFFFF_FFFE);
    wait_done("b2b_second", 32'hFFFF_FFFA, 0, 0, '0, '0, '0);

    // Asynchronous reset in the middle of ITER
    start_op(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid busy", 64'(bus.o_busy), 64'd0);
    chk("rst_mid done", 64'(bus.o_done), 64'd0);
    chk("rst_mid result", 64'(bus.o_result), 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    prev_result = '0;
    saw         = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) saw++;
    end
    chk("rst_mid no_done", 64'(saw), 64'd0);
    start_op(MUL_OP_MULHSU, 32'hFFFF_FFFE, 32'h0000_0005);
    wait_done("after_rst", model(MUL_OP_MULHSU, 32'hFFFF_FFFE, 32'h0000_0005), 0, 0,
              '0, '0, '0);

    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (i == 0) a = '0;
      if (i == 1) b = 32'h8000_0000;
      if (i == 2) a = 32'h8000_0000;
      start_op(op, a, b);
      wait_done($sformatf("rand%0d op%0d", i, op), model(op, a, b), 0, 0, '0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
